snake_head_mover: RTL and testbench



---
 rtl/snake_head_mover.sv | 84 ++++++++
 tb/tb_snake_head_mover.sv | 88 ++++++++
 2 files changed

// File: rtl/snake_head_mover.sv
// snake_head_mover: steps head (headX,headY) one cell per TICK_DIV cycles in the one-hot dir (dirL/U/D/R), IDLE/RUN/DEAD on start/wall hit; outputs moveTick pulse, gameOver level
module snake_head_mover #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int START_X  = 8,
  parameter int START_Y  = 8,
  parameter int TICK_DIV = 25000000,
  parameter int XW       = $clog2(GRID_W),
  parameter int YW       = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dirL,
  input  logic          dirU,
  input  logic          dirD,
  input  logic          dirR,
  input  logic          start,
  output logic [XW-1:0] headX,
  output logic [YW-1:0] headY,
  output logic          moveTick,
  output logic          gameOver
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X0 = XW'(START_X);
  localparam logic [YW-1:0] Y0 = YW'(START_Y);
  localparam logic [CW-1:0] C_MAX = CW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q;
  logic move_q, dead_q, valid, hit;
  always_comb begin
    valid = $onehot({dirL, dirU, dirD, dirR});
    hit = valid && ((dirL && x_q == '0) || (dirR && x_q == X_MAX) ||
                    (dirU && y_q == '0) || (dirD && y_q == Y_MAX));
    x_d = dirL ? x_q - 1'b1 : dirR ? x_q + 1'b1 : x_q;
    y_d = dirU ? y_q - 1'b1 : dirD ? y_q + 1'b1 : y_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= X0;
      y_q     <= Y0;
      cnt_q   <= '0;
      move_q  <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      move_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
        RUN: if (cnt_q != C_MAX) cnt_q <= cnt_q + 1'b1;
        else begin
          cnt_q <= '0;
          if (hit) begin
            state_q <= DEAD;
            dead_q  <= 1'b1;
          end else if (valid) begin
            x_q    <= x_d;
            y_q    <= y_d;
            move_q <= 1'b1;
          end
        end
        DEAD: if (start) begin
          state_q <= RUN;
          x_q     <= X0;
          y_q     <= Y0;
          cnt_q   <= '0;
          dead_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign headX    = x_q;
  assign headY    = y_q;
  assign moveTick = move_q;
  assign gameOver = dead_q;
endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: directed vector table plus reset-mid-count sequence for snake_head_mover
module tb_snake_head_mover;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, dirL = 1'b0, dirU = 1'b0, dirD = 1'b0, dirR = 1'b0;
  logic [2:0] headX, headY;
  logic moveTick, gameOver;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  snake_head_mover #(.GRID_W(8), .GRID_H(8), .START_X(3), .START_Y(3), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .dirL(dirL), .dirU(dirU), .dirD(dirD), .dirR(dirR),
    .start(start), .headX(headX), .headY(headY), .moveTick(moveTick), .gameOver(gameOver)
  );
  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] dir;
    logic [2:0] ex;
    logic [2:0] ey;
    logic       emt;
    logic       ego;
  } vec_t;
  localparam logic [3:0] L = 4'b1000, U = 4'b0100, D = 4'b0010, R = 4'b0001, N = 4'b0000;
  vec_t tbl[$];
  function automatic vec_t mk(logic rst, logic st, logic [3:0] dir, logic [2:0] ex, logic [2:0] ey, logic emt, logic ego);
    vec_t v;
    v.rst = rst; v.st = st; v.dir = dir; v.ex = ex; v.ey = ey; v.emt = emt; v.ego = ego;
    return v;
  endfunction
  function automatic void push(logic rst, logic st, logic [3:0] dir, logic [2:0] ex, logic [2:0] ey, logic emt, logic ego);
    tbl.push_back(mk(rst, st, dir, ex, ey, emt, ego));
  endfunction
  function automatic void tick(logic [3:0] d, logic [2:0] px, logic [2:0] py, logic [2:0] nx, logic [2:0] ny, logic mt, logic go);
    repeat (3) push(1'b0, 1'b0, d, px, py, 1'b0, 1'b0);
    push(1'b0, 1'b0, d, nx, ny, mt, go);
  endfunction
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    reset = v.rst;
    start = v.st;
    {dirL, dirU, dirD, dirR} = v.dir;
    @(posedge clk);
    #1;
    checks++;
    if ({headX, headY, moveTick, gameOver} !== {v.ex, v.ey, v.emt, v.ego}) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d tick=%b over=%b, want x=%0d y=%0d tick=%b over=%b",
               name, headX, headY, moveTick, gameOver, v.ex, v.ey, v.emt, v.ego);
    end
  endtask
  initial begin
    push(1'b1, 1'b0, N, 3'd3, 3'd3, 1'b0, 1'b0);
    repeat (10) push(1'b0, 1'b0, N, 3'd3, 3'd3, 1'b0, 1'b0);
    push(1'b0, 1'b1, L, 3'd3, 3'd3, 1'b0, 1'b0);
    tick(L, 3'd3, 3'd3, 3'd2, 3'd3, 1'b1, 1'b0);
    tick(L, 3'd2, 3'd3, 3'd1, 3'd3, 1'b1, 1'b0);
    tick(L, 3'd1, 3'd3, 3'd0, 3'd3, 1'b1, 1'b0);
    tick(L, 3'd0, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1);
    repeat (12) push(1'b0, 1'b0, L, 3'd0, 3'd3, 1'b0, 1'b1);
    push(1'b0, 1'b1, R, 3'd3, 3'd3, 1'b0, 1'b0);
    tick(R, 3'd3, 3'd3, 3'd4, 3'd3, 1'b1, 1'b0);
    tick(R, 3'd4, 3'd3, 3'd5, 3'd3, 1'b1, 1'b0);
    tick(R, 3'd5, 3'd3, 3'd6, 3'd3, 1'b1, 1'b0);
    tick(R, 3'd6, 3'd3, 3'd7, 3'd3, 1'b1, 1'b0);
    tick(R, 3'd7, 3'd3, 3'd7, 3'd3, 1'b0, 1'b1);
    push(1'b0, 1'b1, U, 3'd3, 3'd3, 1'b0, 1'b0);
    tick(U, 3'd3, 3'd3, 3'd3, 3'd2, 1'b1, 1'b0);
    tick(U, 3'd3, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd1, 3'd3, 3'd2, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd2, 3'd3, 3'd3, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd3, 3'd3, 3'd4, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd4, 3'd3, 3'd5, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd5, 3'd3, 3'd6, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd6, 3'd3, 3'd7, 1'b1, 1'b0);
    tick(D, 3'd3, 3'd7, 3'd3, 3'd7, 1'b0, 1'b1);
    push(1'b0, 1'b1, N, 3'd3, 3'd3, 1'b0, 1'b0);
    tick(N, 3'd3, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0);
    tick(L | R, 3'd3, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0);
    tick(R, 3'd3, 3'd3, 3'd4, 3'd3, 1'b1, 1'b0);
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec[%0d]", i));
    apply(mk(1'b0, 1'b1, R, 3'd4, 3'd3, 1'b0, 1'b0), "start_ignored_in_run");
    apply(mk(1'b0, 1'b0, R, 3'd4, 3'd3, 1'b0, 1'b0), "count_to_two");
    apply(mk(1'b1, 1'b0, R, 3'd3, 3'd3, 1'b0, 1'b0), "reset_mid_count");
    for (int k = 0; k < 8; k++)
      apply(mk(1'b0, 1'b0, R, 3'd3, 3'd3, 1'b0, 1'b0), $sformatf("idle_after_reset[%0d]", k));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
